// File: rtl/equiv_sweep_ctrl_pkg.sv
// Shared definitions for the gate-equivalence sweep sequencer: FSM state codes
// and the reduction that flags any implementation disagreeing with the golden one.
package equiv_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int MAX_IMPL = 32;

    // Golden output is bit n-1; every lower bit is compared against it.
    function automatic logic any_mismatch(input logic [MAX_IMPL-1:0] v, input int n);
        logic m;
        m = 1'b0;
        for (int i = 0; i < MAX_IMPL - 1; i++) begin
            if (i < n - 1) begin
                m = m | (v[i] ^ v[n-1]);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/equiv_sweep_ctrl_settle_timer.sv
// Load/decrement settle counter; zero flags the last wait cycle so the
// sequencer can move on to sampling after exactly SETTLE wait cycles.
module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);

    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/equiv_sweep_ctrl.sv
// Sweep sequencer: walks every input vector, waits for the datapath to settle,
// samples all implementations and accumulates mismatches against the golden one.
module equiv_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int N_IMPL = 3,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [N_IMPL-1:0] impl_in,
    output logic [N_IN-1:0]   vec_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              fail_valid,
    output logic [N_IN-1:0]   first_fail
);
    import equiv_sweep_ctrl_pkg::*;

    localparam logic [N_IN-1:0] VEC_LAST = '1;
    localparam state_t          SETTLE_STATE = (SETTLE == 0) ? S_SAMPLE : S_WAIT;

    state_t state, state_nxt;
    logic   sweep_start, sample_en, timer_load, timer_zero;
    logic   mismatch;
    logic [N_IN:0] err_next;

    generate
        if (SETTLE > 0) begin : g_timer
            settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (timer_load),
                .zero  (timer_zero)
            );
        end else begin : g_no_timer
            assign timer_zero = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort overrides everything, including a start arriving in the same cycle.
    always_comb begin
        state_nxt   = state;
        sweep_start = 1'b0;
        sample_en   = 1'b0;
        timer_load  = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sweep_start = 1'b1;
                        timer_load  = 1'b1;
                        state_nxt   = SETTLE_STATE;
                    end
                end
                S_WAIT: begin
                    if (timer_zero) begin
                        state_nxt = S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    sample_en = 1'b1;
                    if (vec_out == VEC_LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        timer_load = 1'b1;
                        state_nxt  = SETTLE_STATE;
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // impl_in only matters while sampling, so X elsewhere never reaches state.
    assign mismatch = sample_en & any_mismatch(MAX_IMPL'(impl_in), N_IMPL);
    assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out    <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else begin
            if (abort) begin
                pass <= 1'b0;
            end
            if (sweep_start) begin
                vec_out    <= '0;
                err_count  <= '0;
                fail_valid <= 1'b0;
                first_fail <= '0;
                pass       <= 1'b0;
            end else if (sample_en) begin
                if (mismatch) begin
                    err_count <= err_next;
                    if (!fail_valid) begin
                        first_fail <= vec_out;
                        fail_valid <= 1'b1;
                    end
                end
                // Increment is the last step of the sweep, so vec_out never wraps.
                if (vec_out == VEC_LAST) begin
                    pass <= (err_next == '0);
                end else begin
                    vec_out <= vec_out + N_IN'(1);
                end
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Directed bench for equiv_sweep_ctrl: default 2-input sweep plus a 3-input,
// zero-settle instance, with a small behavioural model of the implementations.
module tb_equiv_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start, abort;
    logic [2:0] impl_in;
    logic [1:0] vec_out;
    logic       busy, done, pass, fail_valid;
    logic [2:0] err_count;
    logic [1:0] first_fail;

    logic       start3, abort3;
    logic [2:0] impl3;
    logic [2:0] vec3;
    logic       busy3, done3, pass3, fail_valid3;
    logic [3:0] err3;
    logic [2:0] first3;

    int n_cmp;
    int n_fail;
    int mode;

    equiv_sweep_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .impl_in    (impl_in),
        .vec_out    (vec_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .first_fail (first_fail)
    );

    equiv_sweep_ctrl #(.N_IN(3), .N_IMPL(3), .SETTLE(0)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start3),
        .abort      (abort3),
        .impl_in    (impl3),
        .vec_out    (vec3),
        .busy       (busy3),
        .done       (done3),
        .pass       (pass3),
        .err_count  (err3),
        .fail_valid (fail_valid3),
        .first_fail (first3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Implementations: golden and impl1 are a&b; impl0 is a&b, a|b or ~(a&b).
    always_comb begin
        logic a, b, g, i0;
        a  = vec_out[1];
        b  = vec_out[0];
        g  = a & b;
        i0 = g;
        if (mode == 1) i0 = a | b;
        if (mode == 2) i0 = ~g;
        impl_in = {g, g, i0};
    end

    assign impl3 = {3{vec3[0] ^ vec3[2]}};

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0; abort3 = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, pass, fail_valid, vec_out, err_count, first_fail} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {busy, done, pass, fail_valid, vec_out, err_count, first_fail});
        end
        n_cmp++;
        if ({busy3, done3, pass3, fail_valid3, vec3, err3, first3} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs3: got %b want 0", {busy3, done3, pass3, fail_valid3, vec3, err3, first3});
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        mode = 0;
        pulse_start();
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            if (cyc % 2 == 1 && cyc <= 7) begin
                n_cmp++;
                if (vec_out !== 2'((cyc - 1) / 2) || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_vec c%0d: got vec=%0d busy=%0b want vec=%0d busy=1", cyc, vec_out, busy, (cyc - 1) / 2);
                end
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc !== 9) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 9", cyc); end
        n_cmp++;
        if (pass !== 1'b1 || err_count !== 3'd0 || fail_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got pass=%0b err=%0d fv=%0b want 1 0 0", pass, err_count, fail_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_hold: got done=%0b busy=%0b pass=%0b want 0 0 1", done, busy, pass);
        end
    endtask

    task automatic test_faulty();
        int cyc;
        mode = 1;
        pulse_start();
        wait_done(1, cyc);
        n_cmp++;
        if (cyc !== 9) begin n_fail++; $display("FAIL faulty_done_cycle: got %0d want 9", cyc); end
        n_cmp++;
        if (err_count !== 3'd2 || first_fail !== 2'b01 || pass !== 1'b0 || fail_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL faulty_result: got err=%0d ff=%0d pass=%0b fv=%0b want 2 1 0 1", err_count, first_fail, pass, fail_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_all_fail();
        int cyc;
        mode = 2;
        pulse_start();
        wait_done(1, cyc);
        n_cmp++;
        if (cyc !== 9 || err_count !== 3'd4 || first_fail !== 2'b00 || pass !== 1'b0 || fail_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL all_fail: got cyc=%0d err=%0d ff=%0d pass=%0b fv=%0b want 9 4 0 0 1", cyc, err_count, first_fail, pass, fail_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_start_busy();
        int cyc;
        mode = 0;
        pulse_start();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (vec_out !== 2'b01) begin n_fail++; $display("FAIL busy_start_vec: got %0d want 1", vec_out); end
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(4, cyc);
        n_cmp++;
        if (cyc !== 9 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_done: got cyc=%0d pass=%0b want 9 1", cyc, pass);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit seen;
        mode = 1;
        pulse_start();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (vec_out !== 2'b10 || err_count !== 3'd1) begin
            n_fail++;
            $display("FAIL abort_pre: got vec=%0d err=%0d want 2 1", vec_out, err_count);
        end
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%0b done=%0b pass=%0b want 0 0 0", busy, done, pass);
        end
        n_cmp++;
        if (err_count !== 3'd1 || first_fail !== 2'b01 || fail_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_partial: got err=%0d ff=%0d fv=%0b want 1 1 1", err_count, first_fail, fail_valid);
        end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got activity=%0b want 0", seen); end
        // abort and start together while idle: no sweep starts
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_same: got busy=%0b want 0", busy); end
    endtask

    task automatic test_mid_reset();
        int cyc;
        mode = 1;
        pulse_start();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (vec_out !== 2'b10 || err_count !== 3'd1) begin
            n_fail++;
            $display("FAIL midrst_pre: got vec=%0d err=%0d want 2 1", vec_out, err_count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, pass, fail_valid, vec_out, err_count, first_fail} !== 10'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: got %b want 0", {busy, done, pass, fail_valid, vec_out, err_count, first_fail});
        end
        @(negedge clk) rst_n = 1'b1;
        pulse_start();
        wait_done(1, cyc);
        n_cmp++;
        if (cyc !== 9 || err_count !== 3'd2 || first_fail !== 2'b01 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_sweep: got cyc=%0d err=%0d ff=%0d pass=%0b want 9 2 1 0", cyc, err_count, first_fail, pass);
        end
        @(negedge clk);
    endtask

    task automatic test_wide();
        int cyc;
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        cyc = 1;
        while (done3 !== 1'b1 && cyc < 40) begin
            if (cyc <= 8) begin
                n_cmp++;
                if (vec3 !== 3'(cyc - 1)) begin
                    n_fail++;
                    $display("FAIL wide_vec c%0d: got %0d want %0d", cyc, vec3, cyc - 1);
                end
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc !== 9 || pass3 !== 1'b1 || err3 !== 4'd0 || fail_valid3 !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_done: got cyc=%0d pass=%0b err=%0d fv=%0b want 9 1 0 0", cyc, pass3, err3, fail_valid3);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_faulty();
        test_all_fail();
        test_start_busy();
        test_abort();
        test_mid_reset();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
